// File: rtl/icache_sa_if.sv
// Fetch port and AXI4 read channel bundle for icache_sa.
// slave = cache side, master = IFU plus memory side.
interface icache_sa_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err,
      output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
      input  axi_arready,
      input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
      output axi_rready
   );

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
      output axi_arready,
      output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
      input  axi_rready
   );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with single-burst AXI4 line refill,
// invalid-first / round-robin replacement and fence_i invalidate-all.
module icache_sa #(
   parameter int NSET       = 16,
   parameter int NWAY       = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   icache_sa_if.slave  bus,
   input  logic        fence_i,
   output logic [31:0] perf_hit,
   output logic [31:0] perf_miss
);
   localparam int OFF_W = $clog2(LINE_WORDS * 4);
   localparam int IDX_W = $clog2(NSET);
   localparam int TAG_W = 32 - OFF_W - IDX_W;
   localparam int WAY_W = $clog2(NWAY);
   localparam int WRD_W = $clog2(LINE_WORDS);
   localparam logic [WRD_W-1:0] LAST_W = WRD_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, MISS_AR, MISS_R, RESP, FLUSH
   } state_t;

   state_t state, state_nx;

   logic [31:2]      addr_q;
   logic [TAG_W-1:0] tag_mem  [NSET][NWAY];
   logic [31:0]      data_mem [NSET][NWAY][LINE_WORDS];
   logic [NWAY-1:0]  valid_q  [NSET];
   logic [WAY_W-1:0] rr_q     [NSET];
   logic [WAY_W-1:0] victim_q;
   logic [WRD_W-1:0] beat_cnt;
   logic             err_q;
   logic             flush_pend;
   logic [31:0]      resp_data_q;
   logic             resp_err_q;
   logic [31:0]      hit_cnt;
   logic [31:0]      miss_cnt;

   logic             hit;
   logic             any_inv;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] victim;

   wire unused_addr = ^bus.req_addr[1:0];

   wire [TAG_W-1:0] tag_a = addr_q[31 -: TAG_W];
   wire [IDX_W-1:0] idx_a = addr_q[OFF_W +: IDX_W];
   wire [WRD_W-1:0] wrd_a = addr_q[2 +: WRD_W];

   wire beat      = (state == MISS_R) && bus.axi_rvalid;
   wire beat_last = bus.axi_rlast || (beat_cnt == LAST_W);
   // A short burst leaves part of the line unfilled, so it is an error.
   wire beat_err  = err_q || (bus.axi_rresp != 2'b00) ||
                    (bus.axi_rlast && (beat_cnt != LAST_W));

   // Downward scan so the lowest-numbered match / invalid way wins.
   always_comb begin
      hit     = 1'b0;
      any_inv = 1'b0;
      hit_way = '0;
      victim  = rr_q[idx_a];
      for (int w = NWAY - 1; w >= 0; w--) begin
         if (valid_q[idx_a][w] && (tag_mem[idx_a][w] == tag_a)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx_a][w]) begin
            any_inv = 1'b1;
            victim  = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (flush_pend)         state_nx = FLUSH;
            else if (bus.req_valid) state_nx = LOOKUP;
         end
         LOOKUP:  state_nx = hit ? RESP : MISS_AR;
         MISS_AR: if (bus.axi_arready) state_nx = MISS_R;
         MISS_R:  if (beat && beat_last) state_nx = RESP;
         RESP:    if (bus.resp_ready) state_nx = IDLE;
         FLUSH:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready   = (state == IDLE) && !flush_pend && !rst;
      bus.resp_valid  = (state == RESP);
      bus.axi_arvalid = (state == MISS_AR);
      bus.axi_rready  = (state == MISS_R);
      bus.axi_araddr  = '0;
      bus.axi_arlen   = '0;
      bus.axi_arsize  = '0;
      bus.axi_arburst = '0;
      if (state == MISS_AR) begin
         bus.axi_araddr  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
         bus.axi_arlen   = 8'(LINE_WORDS - 1);
         bus.axi_arsize  = 3'd2;
         bus.axi_arburst = 2'b01;
      end
   end

   assign bus.resp_data = resp_data_q;
   assign bus.resp_err  = resp_err_q;
   assign perf_hit      = hit_cnt;
   assign perf_miss     = miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         victim_q    <= '0;
         beat_cnt    <= '0;
         err_q       <= 1'b0;
         flush_pend  <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         for (int s = 0; s < NSET; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         if ((state == IDLE) && flush_pend)
            flush_pend <= 1'b0;
         else if (fence_i && (state != FLUSH))
            flush_pend <= 1'b1;

         if (bus.req_valid && bus.req_ready)
            addr_q <= bus.req_addr[31:2];

         if (state == LOOKUP) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
            if (hit) begin
               hit_cnt     <= hit_cnt + 32'd1;
               resp_data_q <= data_mem[idx_a][hit_way][wrd_a];
               resp_err_q  <= 1'b0;
            end else begin
               miss_cnt <= miss_cnt + 32'd1;
               victim_q <= victim;
               if (!any_inv) rr_q[idx_a] <= rr_q[idx_a] + 1'b1;
            end
         end

         if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            err_q    <= beat_err;
            if (beat_cnt == wrd_a) resp_data_q <= bus.axi_rdata;
            if (beat_last) begin
               valid_q[idx_a][victim_q] <= !beat_err;
               resp_err_q               <= beat_err;
            end
         end

         if (state == FLUSH) begin
            for (int s = 0; s < NSET; s++) begin
               valid_q[s] <= '0;
               rr_q[s]    <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (beat) begin
         data_mem[idx_a][victim_q][beat_cnt] <= bus.axi_rdata;
         if (beat_last) tag_mem[idx_a][victim_q] <= tag_a;
      end
   end
endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed vector table, hand-written
// reset/fence sequences and a randomized run against a line-level model.
module tb_icache_sa;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fence_i = 1'b0;
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;

   icache_sa_if bus();

   icache_sa #(.NSET(16), .NWAY(4), .LINE_WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fence_i   (fence_i),
      .perf_hit  (perf_hit),
      .perf_miss (perf_miss)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   bit          mv  [16][4];
   logic [23:0] mt  [16][4];
   int          mrr [16];

   typedef struct {
      int          op;
      logic [31:0] addr;
      int          eb;
      int          el;
      int          hold;
      bit          fen;
      bit          fen0;
      bit          stall;
      bit          x_miss;
      bit          x_err;
      logic [31:0] x_data;
   } vec_t;

   vec_t tv[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:28] == 4'h8) return 32'hA0 + 32'(a[3:2]);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic vec_t mk(input int op, input logic [31:0] addr,
                               input int eb, input int el, input int hold,
                               input bit fen, input bit fen0, input bit stall,
                               input bit xm, input bit xe,
                               input logic [31:0] xd);
      vec_t v;
      v.op = op; v.addr = addr; v.eb = eb; v.el = el; v.hold = hold;
      v.fen = fen; v.fen0 = fen0; v.stall = stall;
      v.x_miss = xm; v.x_err = xe; v.x_data = xd;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.resp_ready  = 1'b0;
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = '0;
      bus.axi_rresp   = 2'b00;
      bus.axi_rlast   = 1'b0;
      fence_i         = 1'b0;
   endtask

   task automatic do_fence();
      fence_i = 1'b1;
      @(negedge clk);
      fence_i = 1'b0;
      check("fence_ready_c1", 32'(bus.req_ready), 0);
      @(negedge clk);
      check("fence_ready_c2", 32'(bus.req_ready), 0);
      @(negedge clk);
      check("fence_ready_c3", 32'(bus.req_ready), 1);
   endtask

   task automatic run_req(input logic [31:0] addr, input int eb,
                          input int el, input int hold, input bit fen,
                          input bit fen0, input bit stall,
                          output bit miss, output logic [31:0] data,
                          output bit err);
      int t = 0;
      int lat = 0;
      int ars = 0;
      int rcyc = 0;
      int beats = 0;
      int nar = 0;
      int held = 0;
      int wc = 0;
      int xbeats;
      bit got = 1'b0;
      bit done = 1'b0;
      bit fdone = 1'b0;
      logic [31:0] la;
      la = {addr[31:4], 4'h0};
      data = '0;
      err = 1'b0;
      while (!bus.req_ready && wc < 20) begin
         @(negedge clk);
         wc++;
      end
      check("req_ready_idle", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      fence_i       = fen0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
         idle_inputs();
         if (bus.axi_arvalid) begin
            ars++;
            check("araddr", bus.axi_araddr, la);
            check("arlen", 32'(bus.axi_arlen), 3);
            check("arsize", 32'(bus.axi_arsize), 2);
            check("arburst", 32'(bus.axi_arburst), 1);
            if (!stall || $urandom_range(0, 2) == 0) begin
               bus.axi_arready = 1'b1;
               nar++;
            end
         end
         if (bus.axi_rready) begin
            rcyc++;
            if (fen && !fdone) begin
               fence_i = 1'b1;
               fdone   = 1'b1;
            end
            if (!stall || $urandom_range(0, 2) != 0) begin
               bus.axi_rvalid = 1'b1;
               bus.axi_rdata  = mem_word(la + 32'(4 * beats));
               bus.axi_rresp  = (beats == eb) ? 2'b10 : 2'b00;
               bus.axi_rlast  = (beats == 3) || (beats == el);
               beats++;
            end
         end
         if (bus.resp_valid) begin
            if (!got) begin
               got  = 1'b1;
               data = bus.resp_data;
               err  = bus.resp_err;
               lat  = t;
            end else begin
               check("resp_data_stable", bus.resp_data, data);
               check("resp_err_stable", 32'(bus.resp_err), 32'(err));
            end
            check("req_ready_in_resp", 32'(bus.req_ready), 0);
            if (held >= hold) begin
               bus.resp_ready = 1'b1;
               done = 1'b1;
            end
            held++;
         end
      end
      check("resp_delivered", 32'(done), 1);
      @(negedge clk);
      idle_inputs();
      check("single_resp", 32'(bus.resp_valid), 0);
      miss = (nar != 0);
      check("ar_count_le1", 32'(nar <= 1), 1);
      if (miss) begin
         xbeats = (el >= 0 && el < 3) ? el + 1 : 4;
         check("miss_latency", 32'(lat), 32'(2 + ars + rcyc));
         check("beats_taken", 32'(beats), 32'(xbeats));
      end else begin
         check("hit_latency", 32'(lat), 2);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 16; s++) begin
         mrr[s] = 0;
         for (int w = 0; w < 4; w++) mv[s][w] = 1'b0;
      end
   endtask

   initial begin
      bit          m;
      bit          e;
      logic [31:0] d;
      logic [31:0] a;
      int eb, el, hold, idx, hw, v, lb, wc;
      bit fen, f0, st, em, ee;
      logic [23:0] tg;

      tv.push_back(mk(0, 32'h8000_0004, -1, -1, 0, 0, 0, 0, 1, 0, 32'hA1));
      tv.push_back(mk(0, 32'h8000_000C, -1, -1, 0, 0, 0, 0, 0, 0, 32'hA3));
      tv.push_back(mk(1, 32'h0, -1, -1, 0, 0, 0, 0, 0, 0, 32'h0));
      for (int k = 0; k < 5; k++) begin
         a = 32'h1000_0000 + 32'(k * 32'h100) + 32'(4 * (k % 4));
         tv.push_back(mk(0, a, -1, -1, 0, 0, 0, 0, 1, 0, mem_word(a)));
      end
      tv.push_back(mk(0, 32'h1000_0104, -1, -1, 0, 0, 0, 0, 0, 0,
                      mem_word(32'h1000_0104)));
      tv.push_back(mk(0, 32'h1000_0000, -1, -1, 0, 0, 0, 0, 1, 0,
                      mem_word(32'h1000_0000)));
      tv.push_back(mk(0, 32'h1000_0008, -1, -1, 0, 0, 0, 0, 0, 0,
                      mem_word(32'h1000_0008)));
      tv.push_back(mk(0, 32'h2000_0044, 1, -1, 0, 0, 0, 0, 1, 1, 32'h0));
      tv.push_back(mk(0, 32'h2000_0044, -1, -1, 0, 0, 0, 0, 1, 0,
                      mem_word(32'h2000_0044)));
      tv.push_back(mk(0, 32'h2000_0044, -1, -1, 0, 0, 0, 0, 0, 0,
                      mem_word(32'h2000_0044)));
      tv.push_back(mk(0, 32'h2000_0088, -1, 1, 0, 0, 0, 0, 1, 1, 32'h0));
      tv.push_back(mk(0, 32'h2000_0088, -1, -1, 0, 0, 0, 0, 1, 0,
                      mem_word(32'h2000_0088)));
      tv.push_back(mk(0, 32'h3000_0014, -1, -1, 5, 0, 0, 1, 1, 0,
                      mem_word(32'h3000_0014)));
      tv.push_back(mk(0, 32'h3000_001C, -1, -1, 5, 0, 0, 1, 0, 0,
                      mem_word(32'h3000_001C)));
      tv.push_back(mk(0, 32'h4000_0000, -1, -1, 0, 1, 0, 0, 1, 0,
                      mem_word(32'h4000_0000)));
      tv.push_back(mk(0, 32'h4000_0000, -1, -1, 0, 0, 0, 0, 1, 0,
                      mem_word(32'h4000_0000)));
      tv.push_back(mk(0, 32'h4000_0000, -1, -1, 0, 0, 0, 0, 0, 0,
                      mem_word(32'h4000_0000)));
      tv.push_back(mk(0, 32'h5000_0008, -1, -1, 0, 0, 1, 0, 1, 0,
                      mem_word(32'h5000_0008)));
      tv.push_back(mk(0, 32'h5000_0008, -1, -1, 0, 0, 0, 0, 1, 0,
                      mem_word(32'h5000_0008)));

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_arvalid", 32'(bus.axi_arvalid), 0);
      check("rst_rready", 32'(bus.axi_rready), 0);
      check("rst_resp_data", bus.resp_data, 0);
      check("rst_perf_hit", perf_hit, 0);
      check("rst_perf_miss", perf_miss, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(bus.req_ready), 1);

      foreach (tv[i]) begin
         if (tv[i].op == 1) begin
            do_fence();
         end else begin
            run_req(tv[i].addr, tv[i].eb, tv[i].el, tv[i].hold, tv[i].fen,
                    tv[i].fen0, tv[i].stall, m, d, e);
            check($sformatf("v%0d_miss", i), 32'(m), 32'(tv[i].x_miss));
            check($sformatf("v%0d_err", i), 32'(e), 32'(tv[i].x_err));
            if (!tv[i].x_err)
               check($sformatf("v%0d_data", i), d, tv[i].x_data);
            if (tv[i].x_miss) exp_miss++;
            else exp_hits++;
         end
      end

      do_fence();
      model_clear();
      for (int n = 0; n < 300; n++) begin
         a = 32'h5000_0000 | (32'($urandom_range(0, 5)) << 12) |
             (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2);
         eb   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
         el   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1;
         fen  = ($urandom_range(0, 19) == 0);
         f0   = ($urandom_range(0, 29) == 0);
         hold = int'($urandom_range(0, 3));
         st   = $urandom_range(0, 1) == 1;
         idx  = int'(a[7:4]);
         tg   = a[31:8];
         hw   = -1;
         for (int w = 3; w >= 0; w--)
            if (mv[idx][w] && mt[idx][w] == tg) hw = w;
         em = (hw < 0);
         ee = 1'b0;
         if (em) begin
            lb = (el >= 0) ? el : 3;
            ee = (eb >= 0 && eb <= lb) || (el >= 0);
            v  = -1;
            for (int w = 3; w >= 0; w--)
               if (!mv[idx][w]) v = w;
            if (v < 0) begin
               v = mrr[idx];
               mrr[idx] = (mrr[idx] + 1) % 4;
            end
            mv[idx][v] = !ee;
            mt[idx][v] = tg;
            exp_miss++;
         end else begin
            exp_hits++;
         end
         run_req(a, eb, el, hold, fen, f0, st, m, d, e);
         check("rnd_miss", 32'(m), 32'(em));
         check("rnd_err", 32'(e), 32'(ee));
         if (!ee) check("rnd_data", d, mem_word(a));
         if (f0 || (fen && em)) model_clear();
      end

      check("perf_hit", perf_hit, 32'(exp_hits));
      check("perf_miss", perf_miss, 32'(exp_miss));

      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h6000_0000;
      @(negedge clk);
      bus.req_valid = 1'b0;
      wc = 0;
      while (!bus.axi_rready && wc < 20) begin
         bus.axi_arready = bus.axi_arvalid;
         @(negedge clk);
         wc++;
      end
      bus.axi_arready = 1'b0;
      check("mid_reach_r", 32'(bus.axi_rready), 1);
      bus.axi_rvalid = 1'b1;
      bus.axi_rdata  = 32'hDEAD_0000;
      @(negedge clk);
      bus.axi_rvalid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst_arvalid", 32'(bus.axi_arvalid), 0);
      check("mid_rst_rready", 32'(bus.axi_rready), 0);
      check("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
      check("mid_rst_perf_miss", perf_miss, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 32'(bus.req_ready), 1);
      run_req(32'h6000_0004, -1, -1, 0, 0, 0, 0, m, d, e);
      check("mid_rst_miss", 32'(m), 1);
      check("mid_rst_data", d, mem_word(32'h6000_0004));
      check("mid_rst_perf", perf_miss, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
